seq_mult_unsigned: RTL and testbench



---
 rtl/seq_mult_unsigned_pkg.sv | 9 +
 rtl/seq_mult_unsigned_if.sv | 8 +
 rtl/seq_mult_unsigned_rca_nbit.sv | 39 +++
 rtl/seq_mult_unsigned.sv | 72 +++++++
 tb/tb_seq_mult_unsigned.sv | 139 +++++++++++++
 5 files changed

// File: rtl/seq_mult_unsigned_pkg.sv
// seq_mult_unsigned_pkg: package mult_pkg with shared FSM state encoding and default operand width
package mult_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/seq_mult_unsigned_if.sv
// seq_mult_unsigned_if: operand/product handshake bundle; master = producer+consumer side (in_valid, a, b, out_ready), slave = multiplier (in_ready, out_valid, p, busy)
interface seq_mult_unsigned_if #(parameter int WIDTH = mult_pkg::DEF_WIDTH);
  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic [WIDTH-1:0] a, b;
  logic [2*WIDTH-1:0] p;
  modport master(output in_valid, a, b, out_ready, input in_ready, out_valid, p, busy);
  modport slave(input in_valid, a, b, out_ready, output in_ready, out_valid, p, busy);
endinterface

// File: rtl/seq_mult_unsigned_rca_nbit.sv
// rca_nbit: N-bit ripple-carry adder (x, y -> s, carry-out dropped) built from half/full adder cells
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic co
);
  assign s = x ^ y;
  assign co = x & y;
endmodule

module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module rca_nbit #(parameter int N = 2 * mult_pkg::DEF_WIDTH) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic [N-1:0] s
);
  logic [N-2:0] c;
  for (genvar i = 0; i < N; i++) begin : g_bit
    if (i == 0) begin : g_ha
      half_adder u_ha (.x(x[0]), .y(y[0]), .s(s[0]), .co(c[0]));
    end else if (i == N - 1) begin : g_msb
      // the caller guarantees no overflow, so the top carry is never built
      assign s[i] = x[i] ^ y[i] ^ c[i-1];
    end else begin : g_fa
      full_adder u_fa (.x(x[i]), .y(y[i]), .ci(c[i-1]), .s(s[i]), .co(c[i]));
    end
  end
endmodule

// File: rtl/seq_mult_unsigned.sv
// seq_mult_unsigned: iterative shift-add WIDTHxWIDTH unsigned multiplier; ports clk, rst_n (sync active-low), s (slave handshake bundle); SEQ_MULT_EARLY_TERM_EN ends once the remaining multiplier bits are zero
module seq_mult_unsigned
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic clk,
  input logic rst_n,
  seq_mult_unsigned_if.slave s
);
  localparam int CNT_W = $clog2(WIDTH);
  state_t state;
  logic [2*WIDTH-1:0] acc, mcand, sum, acc_nxt;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic last;
  rca_nbit #(.N(2 * WIDTH)) u_add (.x(acc), .y(mcand), .s(sum));
  assign acc_nxt = mplier[0] ? sum : acc;
`ifdef SEQ_MULT_EARLY_TERM_EN
  assign last = (cnt == CNT_W'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
`else
  assign last = cnt == CNT_W'(WIDTH - 1);
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      s.in_ready <= 1'b1;
      s.out_valid <= 1'b0;
      s.busy <= 1'b0;
      s.p <= '0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (s.in_valid) begin
          state <= BUSY;
          s.in_ready <= 1'b0;
          s.busy <= 1'b1;
          acc <= '0;
          mcand <= {{WIDTH{1'b0}}, s.a};
          mplier <= s.b;
          cnt <= '0;
        end
        BUSY: begin
          acc <= acc_nxt;
          mcand <= mcand << 1;
          mplier <= mplier >> 1;
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            s.out_valid <= 1'b1;
            s.p <= acc_nxt;
          end
        end
        DONE: if (s.out_ready) begin
          state <= IDLE;
          s.out_valid <= 1'b0;
          s.in_ready <= 1'b1;
          s.busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
          s.out_valid <= 1'b0;
          s.in_ready <= 1'b1;
          s.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_mult_unsigned.sv
// tb_seq_mult_unsigned: directed-vector bench for 8-bit and 16-bit multiplier instances
module tb_seq_mult_unsigned;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  seq_mult_unsigned_if #(.WIDTH(8)) m8 ();
  seq_mult_unsigned_if #(.WIDTH(16)) m16 ();
  seq_mult_unsigned #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .s(m8));
  seq_mult_unsigned #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .s(m16));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic int exp_lat(input logic [31:0] bv, input int w);
    int h;
    h = w;
`ifdef SEQ_MULT_EARLY_TERM_EN
    h = 1;
    for (int i = 0; i < w; i++) if (bv[i]) h = i + 1;
`endif
    return h;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_done8(input string tag, input int lat, input logic [15:0] ep);
    int n;
    n = 0;
    while (!m8.out_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(lat));
    check({tag, "_p"}, 64'(m8.p), 64'(ep));
  endtask
  task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb_v, input logic [15:0] ep, input int hold);
    check({tag, "_rdy"}, 64'(m8.in_ready), 64'd1);
    m8.out_ready = 1'b0;
    m8.a = ta;
    m8.b = tb_v;
    m8.in_valid = 1'b1;
    tick();
    m8.in_valid = 1'b0;
    m8.a = 8'($urandom);
    m8.b = 8'($urandom);
    check({tag, "_busy"}, 64'(m8.busy), 64'd1);
    wait_done8(tag, exp_lat(32'(tb_v), 8), ep);
    for (int i = 0; i < hold; i++) begin
      m8.in_valid = i[0];
      tick();
      check({tag, "_hold_p"}, 64'(m8.p), 64'(ep));
      check({tag, "_hold_ov"}, 64'(m8.out_valid), 64'd1);
      check({tag, "_hold_ir"}, 64'(m8.in_ready), 64'd0);
    end
    m8.in_valid = 1'b0;
    m8.out_ready = 1'b1;
    tick();
    check({tag, "_post_ov"}, 64'(m8.out_valid), 64'd0);
    check({tag, "_post_ir"}, 64'(m8.in_ready), 64'd1);
    m8.out_ready = 1'b0;
  endtask
  initial begin
    int n;
    m8.in_valid = 1'b0; m8.a = '0; m8.b = '0; m8.out_ready = 1'b0;
    m16.in_valid = 1'b0; m16.a = '0; m16.b = '0; m16.out_ready = 1'b0;
    tick();
    tick();
    check("rst_ir", 64'(m8.in_ready), 64'd1);
    check("rst_ov", 64'(m8.out_valid), 64'd0);
    check("rst_busy", 64'(m8.busy), 64'd0);
    check("rst_p", 64'(m8.p), 64'd0);
    rst_n = 1'b1;
    tick();
    op8("ff_ff", 8'hFF, 8'hFF, 16'hFE01, 0);
    op8("zero_a", 8'h00, 8'hA5, 16'h0000, 0);
    op8("zero_b", 8'h37, 8'h00, 16'h0000, 0);
    op8("55_03", 8'h55, 8'h03, 16'h00FF, 0);
    op8("bp", 8'h0D, 8'h0B, 16'h008F, 5);
    m8.out_ready = 1'b1;
    m8.a = 8'h0D;
    m8.b = 8'h0B;
    m8.in_valid = 1'b1;
    tick();
    m8.a = 8'h02;
    m8.b = 8'h07;
    wait_done8("b2b1", exp_lat(32'h0B, 8), 16'h008F);
    tick();
    check("b2b_hs_ov", 64'(m8.out_valid), 64'd0);
    check("b2b_hs_ir", 64'(m8.in_ready), 64'd1);
    tick();
    check("b2b_acc_ir", 64'(m8.in_ready), 64'd0);
    check("b2b_acc_busy", 64'(m8.busy), 64'd1);
    m8.in_valid = 1'b0;
    wait_done8("b2b2", exp_lat(32'h07, 8), 16'h000E);
    tick();
    check("b2b2_post_ir", 64'(m8.in_ready), 64'd1);
    m8.out_ready = 1'b0;
    m8.a = 8'hFF;
    m8.b = 8'hFF;
    m8.in_valid = 1'b1;
    tick();
    m8.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_ir", 64'(m8.in_ready), 64'd1);
    check("abort_ov", 64'(m8.out_valid), 64'd0);
    check("abort_busy", 64'(m8.busy), 64'd0);
    check("abort_p", 64'(m8.p), 64'd0);
    op8("3_5", 8'h03, 8'h05, 16'h000F, 0);
    m16.a = 16'hFFFF;
    m16.b = 16'h8001;
    m16.in_valid = 1'b1;
    tick();
    m16.in_valid = 1'b0;
    m16.a = '0;
    m16.b = '0;
    n = 0;
    while (!m16.out_valid && n < 60) begin
      tick();
      n++;
    end
    check("w16_lat", 64'(n), 64'd16);
    check("w16_p", 64'(m16.p), 64'h8000_7FFF);
    m16.out_ready = 1'b1;
    tick();
    check("w16_post_ir", 64'(m16.in_ready), 64'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
